// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetcher
// Issues word fetches, buffers one instruction for decode, handles PC redirects.
module instr_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign,
    output logic [31:0]     fetch_count
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            redir;
    logic            redir_bad;
    logic            misalign_next;

    assign redir         = redirect_valid && (state != S_ERR);
    assign redir_bad     = redir && (redirect_pc[1:0] != 2'b00);
    assign misalign_next = fetch_misalign || redir_bad;

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign opcode         = inst[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            inst           <= '0;
            inst_pc        <= '0;
            fetch_misalign <= 1'b0;
            fetch_count    <= '0;
        end else begin
            if (redir) begin
                pc <= redirect_pc;
            end
            if (redir_bad) begin
                fetch_misalign <= 1'b1;
            end
            case (state)
                S_REQ: begin
                    // An accepted request already carries the old pc, so its response must be drained.
                    if (redir) begin
                        if (imem_req_ready)     state <= S_DROP;
                        else if (misalign_next) state <= S_ERR;
                        else                    state <= S_REQ;
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        if (!imem_rsp_valid)    state <= S_DROP;
                        else if (misalign_next) state <= S_ERR;
                        else                    state <= S_REQ;
                    end else if (imem_rsp_valid) begin
                        inst    <= imem_rsp_data;
                        inst_pc <= pc;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        if (!redir) begin
                            pc <= pc + XLEN'(4);
                        end
                    end
                    if (redir) begin
                        state <= misalign_next ? S_ERR : S_REQ;
                    end else if (inst_ready) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state <= misalign_next ? S_ERR : S_REQ;
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } inst_exp_t;

    logic [31:0] addr_q[$];
    inst_exp_t   inst_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake on either channel must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                n_vec++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_addr: unexpected request addr=%h, none expected", imem_req_addr);
                end else begin
                    logic [31:0] ea;
                    ea = addr_q.pop_front();
                    if (imem_req_addr !== ea) begin
                        n_err++;
                        $display("FAIL req_addr: got %h expected %h", imem_req_addr, ea);
                    end
                end
            end
            if (inst_valid && inst_ready) begin
                n_vec++;
                if (inst_q.size() == 0) begin
                    n_err++;
                    $display("FAIL inst: unexpected instruction %h pc=%h", inst, inst_pc);
                end else begin
                    inst_exp_t ei;
                    ei = inst_q.pop_front();
                    if (inst !== ei.word || inst_pc !== ei.pc || opcode !== ei.word[6:0]) begin
                        n_err++;
                        $display("FAIL inst: got %h pc=%h op=%h expected %h pc=%h op=%h",
                                 inst, inst_pc, opcode, ei.word, ei.pc, ei.word[6:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Request accepted, response one cycle later, decode takes it immediately.
    task automatic fetch_one(input logic [31:0] data, input logic [31:0] addr);
        addr_q.push_back(addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        inst_q.push_back('{word: data, pc: addr});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        do_reset();

        // T1: reset state and three back-to-back fetches
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
        chk("rst_inst", inst, 32'h0);
        fetch_one(32'h0050_0093, 32'h0);
        fetch_one(32'h00a0_0113, 32'h4);
        fetch_one(32'h0020_81b3, 32'h8);
        chk("t1_count", fetch_count, 32'd3);

        // T2: decode stalls for 5 cycles
        addr_q.push_back(32'hC);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            chk("t2_inst", inst, 32'h0000_0013);
            chk("t2_opcode", 32'(opcode), 32'h13);
            chk("t2_inst_valid", 32'(inst_valid), 32'd1);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
            chk("t2_pc", imem_req_addr, 32'hC);
            tick();
        end
        inst_q.push_back('{word: 32'h0000_0013, pc: 32'hC});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t2_count", fetch_count, 32'd4);

        // T3: redirect while waiting, late response dropped
        addr_q.push_back(32'h10);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_drop_no_req", 32'(imem_req_valid), 32'd0);
        inst_ready     = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t3_no_inst", 32'(inst_valid), 32'd0);
        tick();
        inst_ready = 1'b0;
        chk("t3_no_inst2", 32'(inst_valid), 32'd0);
        chk("t3_addr", imem_req_addr, 32'h100);
        fetch_one(32'h0000_0297, 32'h100);
        chk("t3_count", fetch_count, 32'd5);

        // T4: redirect coinciding with a decode handshake at pc 0x8
        do_reset();
        fetch_one(32'h0000_0033, 32'h0);
        fetch_one(32'h0000_0063, 32'h4);
        addr_q.push_back(32'h8);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_006F;
        tick();
        imem_rsp_valid = 1'b0;
        inst_q.push_back('{word: 32'h0000_006F, pc: 32'h8});
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_count", fetch_count, 32'd3);
        chk("t4_addr", imem_req_addr, 32'h200);
        fetch_one(32'h0000_0013, 32'h200);

        // T5: misaligned redirect locks the unit until reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_misalign", 32'(fetch_misalign), 32'd1);
            chk("t5_no_req", 32'(imem_req_valid), 32'd0);
            chk("t5_no_inst", 32'(inst_valid), 32'd0);
            tick();
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        do_reset();
        chk("t5_rst_misalign", 32'(fetch_misalign), 32'd0);
        chk("t5_rst_req", 32'(imem_req_valid), 32'd1);
        chk("t5_rst_count", fetch_count, 32'd0);

        // T6: stalled request retargeted, then counter wrap
        for (int i = 0; i < 4; i++) begin
            chk("t6_stall_req", 32'(imem_req_valid), 32'd1);
            chk("t6_stall_addr", imem_req_addr, 32'h0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("t6_req", 32'(imem_req_valid), 32'd1);
        chk("t6_addr", imem_req_addr, 32'h300);
        fetch_one(32'h0000_0017, 32'h300);
        chk("t6_count1", fetch_count, 32'd1);
        force dut.fetch_count = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_count;
        tick();
        chk("t6_preload", fetch_count, 32'hFFFF_FFFF);
        fetch_one(32'h0000_0037, 32'h304);
        chk("t6_wrap", fetch_count, 32'h0);

        tick();
        chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
        chk("inst_q_empty", 32'(inst_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
